// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite line fetch path: FSM state codes,
// descriptor field positions and the default background address.
package sprite_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int unsigned DESC_W = 32;

    // Descriptor layout from bit 0 upward: offset, y, x, mirror_x, mirror_y.
    function automatic int unsigned desc_y_lsb(input int unsigned offset_w);
        return offset_w;
    endfunction

    function automatic int unsigned desc_x_lsb(input int unsigned offset_w,
                                               input int unsigned coord_w);
        return offset_w + coord_w;
    endfunction

    function automatic int unsigned desc_mx_bit(input int unsigned offset_w,
                                                input int unsigned coord_w);
        return offset_w + 2 * coord_w;
    endfunction

    function automatic int unsigned desc_my_bit(input int unsigned offset_w,
                                                input int unsigned coord_w);
        return offset_w + 2 * coord_w + 1;
    endfunction

    function automatic int unsigned desc_used_w(input int unsigned offset_w,
                                                input int unsigned coord_w);
        return offset_w + 2 * coord_w + 2;
    endfunction

    function automatic logic [63:0] bg_addr_default(input int unsigned addr_w);
        return (64'd1 << addr_w) - 64'd1;
    endfunction

endpackage

// File: rtl/sprite_addr_calc.sv
// Combinational sprite pixel address: offset*area + row*width + col, with
// optional mirroring, wrapped modulo 2^ADDR_W.
module sprite_addr_calc
    import sprite_pkg::*;
#(
    parameter int unsigned COORD_W  = 10,
    parameter int unsigned OFFSET_W = 9,
    parameter int unsigned SPRITE_W = 20,
    parameter int unsigned SPRITE_H = 20,
    parameter int unsigned ADDR_W   = 14,
    parameter int unsigned COL_W    = 5
) (
    input  logic [OFFSET_W-1:0] offset,
    input  logic [COORD_W-1:0]  row,
    input  logic [COL_W-1:0]    col,
    input  logic                mirror_x,
    input  logic                mirror_y,
    output logic [ADDR_W-1:0]   addr
);

    localparam logic [ADDR_W-1:0] AREA_A  = ADDR_W'(SPRITE_W * SPRITE_H);
    localparam logic [ADDR_W-1:0] WIDTH_A = ADDR_W'(SPRITE_W);
    localparam logic [ADDR_W-1:0] H_LAST  = ADDR_W'(SPRITE_H - 1);
    localparam logic [ADDR_W-1:0] W_LAST  = ADDR_W'(SPRITE_W - 1);

    logic [ADDR_W-1:0] off_a;
    logic [ADDR_W-1:0] row_a;
    logic [ADDR_W-1:0] col_a;
    logic [ADDR_W-1:0] r_eff;
    logic [ADDR_W-1:0] c_eff;

    // Arithmetic modulo 2^ADDR_W throughout equals truncating the exact result.
    always_comb begin
        off_a = ADDR_W'(offset);
        row_a = ADDR_W'(row);
        col_a = ADDR_W'(col);
        r_eff = mirror_y ? (H_LAST - row_a) : row_a;
        c_eff = mirror_x ? (W_LAST - col_a) : col_a;
        addr  = off_a * AREA_A + r_eff * WIDTH_A + c_eff;
    end

endmodule

// File: rtl/sprite_line_fetch.sv
// Per-scanline sprite address generator: latches a descriptor on sprite_on and
// streams SPRITE_W sprite-memory addresses on the falling pixel clock edge.
module sprite_line_fetch
    import sprite_pkg::*;
#(
    parameter int unsigned COORD_W  = 10,
    parameter int unsigned OFFSET_W = 9,
    parameter int unsigned SPRITE_W = 20,
    parameter int unsigned SPRITE_H = 20,
    parameter int unsigned ADDR_W   = 14,
    parameter logic [ADDR_W-1:0] BG_ADDR = ADDR_W'(bg_addr_default(ADDR_W))
) (
    input  logic               clk_pixel,
    input  logic               reset_n,
    input  logic [COORD_W-1:0] pixel_y,
    input  logic [31:0]        sprite_datas,
    input  logic               sprite_on,
    output logic [ADDR_W-1:0]  memory_address,
    output logic               addr_valid,
    output logic               counter_finished
);

    localparam int unsigned COL_W  = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int unsigned Y_LSB  = desc_y_lsb(OFFSET_W);
    localparam int unsigned MX_BIT = desc_mx_bit(OFFSET_W, COORD_W);
    localparam int unsigned MY_BIT = desc_my_bit(OFFSET_W, COORD_W);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(SPRITE_W - 1);

    if (desc_used_w(OFFSET_W, COORD_W) > DESC_W) begin : g_desc_chk
        $error("sprite descriptor fields do not fit in 32 bits");
    end
    if (SPRITE_W < 2 || SPRITE_H < 1) begin : g_size_chk
        $error("sprite must be at least 2 pixels wide and 1 line high");
    end

    logic [1:0]          state_q;
    logic [COL_W-1:0]    col_q;
    logic [OFFSET_W-1:0] off_q;
    logic [COORD_W-1:0]  row_q;
    logic                mx_q;
    logic                my_q;

    logic [OFFSET_W-1:0] in_offset;
    logic [COORD_W-1:0]  in_y;
    logic [COORD_W-1:0]  in_row;
    logic                in_mx;
    logic                in_my;
    logic                in_visible;
    logic                unused_desc;

    logic [OFFSET_W-1:0] calc_offset;
    logic [COORD_W-1:0]  calc_row;
    logic [COL_W-1:0]    calc_col;
    logic                calc_mx;
    logic                calc_my;
    logic [ADDR_W-1:0]   calc_addr;

    // The x field and the spare upper bits are carried but never decoded here.
    assign unused_desc = ^sprite_datas;

    always_comb begin
        in_offset  = sprite_datas[OFFSET_W-1:0];
        in_y       = sprite_datas[Y_LSB +: COORD_W];
        in_mx      = sprite_datas[MX_BIT];
        in_my      = sprite_datas[MY_BIT];
        in_row     = pixel_y - in_y;
        in_visible = (pixel_y >= in_y) && (32'(in_row) < SPRITE_H);
    end

    // In IDLE the incoming descriptor drives the calculator so col 0 lands on the start edge.
    always_comb begin
        calc_offset = off_q;
        calc_row    = row_q;
        calc_mx     = mx_q;
        calc_my     = my_q;
        calc_col    = col_q + COL_W'(1);
        if (state_q == ST_IDLE) begin
            calc_offset = in_offset;
            calc_row    = in_row;
            calc_mx     = in_mx;
            calc_my     = in_my;
            calc_col    = '0;
        end
    end

    sprite_addr_calc #(
        .COORD_W  (COORD_W),
        .OFFSET_W (OFFSET_W),
        .SPRITE_W (SPRITE_W),
        .SPRITE_H (SPRITE_H),
        .ADDR_W   (ADDR_W),
        .COL_W    (COL_W)
    ) u_addr_calc (
        .offset   (calc_offset),
        .row      (calc_row),
        .col      (calc_col),
        .mirror_x (calc_mx),
        .mirror_y (calc_my),
        .addr     (calc_addr)
    );

    always_ff @(negedge clk_pixel) begin
        if (state_q == ST_IDLE && sprite_on) begin
            off_q <= in_offset;
            row_q <= in_row;
            mx_q  <= in_mx;
            my_q  <= in_my;
        end
    end

    always_ff @(negedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= ST_IDLE;
            col_q            <= '0;
            memory_address   <= BG_ADDR;
            addr_valid       <= 1'b0;
            counter_finished <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    col_q            <= '0;
                    memory_address   <= BG_ADDR;
                    addr_valid       <= 1'b0;
                    counter_finished <= 1'b0;
                    if (sprite_on) begin
                        if (in_visible) begin
                            state_q        <= ST_RUN;
                            memory_address <= calc_addr;
                            addr_valid     <= 1'b1;
                        end else begin
                            state_q          <= ST_DONE;
                            counter_finished <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (!sprite_on) begin
                        state_q          <= ST_IDLE;
                        col_q            <= '0;
                        memory_address   <= BG_ADDR;
                        addr_valid       <= 1'b0;
                        counter_finished <= 1'b0;
                    end else if (col_q == COL_LAST) begin
                        state_q          <= ST_DONE;
                        col_q            <= '0;
                        memory_address   <= BG_ADDR;
                        addr_valid       <= 1'b0;
                        counter_finished <= 1'b1;
                    end else begin
                        col_q            <= col_q + COL_W'(1);
                        memory_address   <= calc_addr;
                        addr_valid       <= 1'b1;
                        counter_finished <= 1'b0;
                    end
                end
                default: begin
                    state_q          <= ST_IDLE;
                    col_q            <= '0;
                    memory_address   <= BG_ADDR;
                    addr_valid       <= 1'b0;
                    counter_finished <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_line_fetch.sv
// Scoreboard bench for sprite_line_fetch: a transaction-level model queues the
// expected output of every falling edge and a monitor compares them.
module tb_sprite_line_fetch;

    localparam int W  = 20;
    localparam int H  = 20;
    localparam logic [13:0] BG = 14'h3FFF;

    typedef struct {
        logic [13:0] addr;
        logic        valid;
        logic        fin;
    } rec_t;

    logic        clk_pixel;
    logic        reset_n;
    logic [9:0]  pixel_y;
    logic [31:0] sprite_datas;
    logic        sprite_on;
    logic [13:0] memory_address;
    logic        addr_valid;
    logic        counter_finished;

    rec_t exp_q[$];
    bit   mon_en;
    int   checks;
    int   errors;
    int   cyc;

    sprite_line_fetch dut (
        .clk_pixel        (clk_pixel),
        .reset_n          (reset_n),
        .pixel_y          (pixel_y),
        .sprite_datas     (sprite_datas),
        .sprite_on        (sprite_on),
        .memory_address   (memory_address),
        .addr_valid       (addr_valid),
        .counter_finished (counter_finished)
    );

    initial clk_pixel = 1'b1;
    always #5 clk_pixel = ~clk_pixel;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    // Spec-level address rule, evaluated with plain integers.
    function automatic logic [13:0] model_addr(input int off, input int row, input int k,
                                               input bit mx, input bit my);
        int r;
        int c;
        r = my ? (H - 1 - row) : row;
        c = mx ? (W - 1 - k) : k;
        return 14'((off * W * H + r * W + c) % 16384);
    endfunction

    function automatic logic [31:0] pack_desc(input int off, input int y, input int x,
                                              input bit mx, input bit my);
        logic [31:0] d;
        d        = $urandom;
        d[8:0]   = 9'(off);
        d[18:9]  = 10'(y);
        d[28:19] = 10'(x);
        d[29]    = mx;
        d[30]    = my;
        return d;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One falling edge: drive inputs, queue what that edge must produce.
    task automatic step(input logic on, input logic [31:0] datas, input logic [9:0] py,
                        input logic [13:0] ea, input logic ev, input logic ef);
        rec_t r;
        sprite_on    = on;
        sprite_datas = datas;
        pixel_y      = py;
        r.addr  = ea;
        r.valid = ev;
        r.fin   = ef;
        exp_q.push_back(r);
        @(negedge clk_pixel);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, $urandom, 10'($urandom), BG, 1'b0, 1'b0);
    endtask

    // abort_n = 0: full line; otherwise sprite_on drops after abort_n addresses.
    task automatic txn(input int off, input int y, input int x, input bit mx, input bit my,
                       input int py, input int abort_n);
        logic [31:0] datas;
        bit          visible;
        int          n;
        datas   = pack_desc(off, y, x, mx, my);
        visible = (py >= y) && (py - y < H);
        if (!visible) begin
            step(1'b1, datas, 10'(py), BG, 1'b0, 1'b1);
            step(1'($urandom_range(0, 1)), $urandom, 10'($urandom), BG, 1'b0, 1'b0);
            return;
        end
        n = (abort_n > 0) ? abort_n : W;
        for (int k = 0; k < n; k++) begin
            if (k == 0) step(1'b1, datas, 10'(py), model_addr(off, py - y, k, mx, my), 1'b1, 1'b0);
            else step(1'b1, $urandom, 10'($urandom), model_addr(off, py - y, k, mx, my), 1'b1, 1'b0);
        end
        if (abort_n > 0) begin
            step(1'b0, $urandom, 10'($urandom), BG, 1'b0, 1'b0);
        end else begin
            step(1'b1, $urandom, 10'($urandom), BG, 1'b0, 1'b1);
            step(1'($urandom_range(0, 1)), $urandom, 10'($urandom), BG, 1'b0, 1'b0);
        end
    endtask

    initial begin
        rec_t e;
        forever begin
            @(negedge clk_pixel);
            #1;
            if (mon_en) begin
                cyc++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard cycle %0d: output seen but expected queue empty", cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (memory_address !== e.addr || addr_valid !== e.valid ||
                        counter_finished !== e.fin) begin
                        errors++;
                        $display("FAIL out cycle %0d: got addr=%0d valid=%0b fin=%0b expected addr=%0d valid=%0b fin=%0b",
                                 cyc, memory_address, addr_valid, counter_finished,
                                 e.addr, e.valid, e.fin);
                    end
                end
            end
        end
    end

    initial begin
        int off, y, x, py, ab;
        checks       = 0;
        errors       = 0;
        cyc          = 0;
        mon_en       = 1'b0;
        reset_n      = 1'b1;
        sprite_on    = 1'b0;
        sprite_datas = '0;
        pixel_y      = '0;

        #2 reset_n = 1'b0;
        #1;
        chk("reset_addr", 32'(memory_address), 32'(BG));
        chk("reset_valid", 32'(addr_valid), 0);
        chk("reset_fin", 32'(counter_finished), 0);
        sprite_on = 1'b1;
        repeat (3) @(negedge clk_pixel);
        #2;
        chk("reset_held_valid", 32'(addr_valid), 0);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        idle(2);

        txn(3, 50, 100, 1'b0, 1'b0, 52, 0);
        txn(3, 50, 100, 1'b1, 1'b0, 52, 0);
        txn(3, 50, 100, 1'b0, 1'b1, 52, 0);
        idle(1);
        txn(3, 50, 100, 1'b0, 0, 70, 0);
        txn(3, 50, 100, 1'b0, 0, 49, 0);
        txn(3, 50, 100, 1'b0, 1'b0, 52, 5);
        idle(1);
        txn(511, 0, 7, 1'b1, 1'b1, 19, 0);
        txn(0, 1000, 0, 1'b0, 1'b0, 1019, 0);
        txn(7, 10, 0, 1'b0, 1'b0, 12, W);

        for (int t = 0; t < 40; t++) begin
            off = $urandom_range(0, 511);
            y   = $urandom_range(0, 1000);
            x   = $urandom_range(0, 1023);
            py  = y + int'($urandom_range(0, 24)) - 2;
            if (py < 0) py = 0;
            if (py > 1023) py = 1023;
            ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W)) : 0;
            txn(off, y, x, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), py, ab);
            idle($urandom_range(0, 2));
        end

        mon_en       = 1'b0;
        sprite_on    = 1'b1;
        sprite_datas = pack_desc(3, 50, 100, 1'b0, 1'b0);
        pixel_y      = 10'd52;
        repeat (3) @(negedge clk_pixel);
        #3;
        chk("midrun_addr", 32'(memory_address), 32'(model_addr(3, 2, 2, 1'b0, 1'b0)));
        chk("midrun_valid", 32'(addr_valid), 1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_addr", 32'(memory_address), 32'(BG));
        chk("async_rst_valid", 32'(addr_valid), 0);
        chk("async_rst_fin", 32'(counter_finished), 0);
        @(negedge clk_pixel);
        #2;
        chk("rst_hold_addr", 32'(memory_address), 32'(BG));
        reset_n = 1'b1;
        mon_en  = 1'b1;
        txn(3, 50, 100, 1'b0, 1'b0, 52, 0);
        idle(2);
        mon_en = 1'b0;

        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_line_fetch.md
# sprite_line_fetch

Parametrised per-line sprite address generator for the sprite pipeline, the successor to the fixed 20×20 sprite line counter. On a `sprite_on` start it latches one sprite descriptor and the current scanline. If the sprite covers that line, it streams `SPRITE_W` sprite-memory addresses, one per pixel clock, with optional horizontal and vertical mirroring. It then pulses `counter_finished`. It sits between the sprite register bank and the sprite memory read port, ahead of the pixel mixer.

## Interface
- `COORD_W`, 10, width of screen and sprite coordinates
- `OFFSET_W`, 9, width of the sprite index (offset) field
- `SPRITE_W`, 20, sprite width in pixels, ≥2
- `SPRITE_H`, 20, sprite height in lines, ≥1
- `ADDR_W`, 14, memory address width
- `BG_ADDR`, 2^ADDR_W−1, idle/background address
- `clk_pixel  in  1  pixel clock; all state updates on the falling edge`
- `reset_n  in  1  asynchronous, active-low reset`
- `pixel_y  in  COORD_W  current scanline`
- `sprite_datas  in  32  descriptor: [OFFSET_W-1:0]` offset; next `COORD_W` bits y; next `COORD_W` bits x; next bit mirror_x; next bit mirror_y; upper bits ignored. Elaboration check: `2*COORD_W+OFFSET_W+2 ≤ 32`.
- `sprite_on  in  1  start / keep-alive`
- `memory_address  out  ADDR_W  registered sprite memory address`
- `addr_valid  out  1  memory_address is a sprite pixel address`
- `counter_finished  out  1  one-cycle pulse: line fetch complete`

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**, `sprite_on`=1: latch the descriptor and `row = pixel_y − y` (COORD_W-bit, unsigned).
  - If `pixel_y ≥ y` and `row < SPRITE_H`: enter RUN, col=0.
  - Otherwise: enter DONE without emitting any address.
- **RUN**: emit the address for col k, then k+1 → col. After col `SPRITE_W−1` is emitted, enter DONE.
  - If `sprite_on`=0 is sampled, abort to IDLE: outputs return to idle values and no finished pulse is produced.
- **DONE**: `counter_finished`=1, `memory_address`=BG_ADDR, `addr_valid`=0. Next edge enters IDLE unconditionally.
- Address arithmetic:
  - `r = mirror_y ? SPRITE_H−1−row : row`
  - `c = mirror_x ? SPRITE_W−1−k : k`
  - `addr = offset*(SPRITE_W*SPRITE_H) + r*SPRITE_W + c`
  - Compute at full precision, then truncate modulo 2^ADDR_W; no saturation.
- Descriptor and row are latched at start. Changes to `sprite_datas` or `pixel_y` during RUN are ignored.
- Holding `sprite_on` high across lines restarts on the edge after DONE→IDLE.

## Timing
- Reset values: state IDLE, col 0, `memory_address`=BG_ADDR, `addr_valid`=0, `counter_finished`=0.
- Start accepted at falling edge E0. The address for col 0 is registered at E0, using combinational decode of the incoming descriptor.
- Col k appears at edge E0+k. Edge E0+SPRITE_W enters DONE, pulse is high for one cycle. Edge E0+SPRITE_W+1 enters IDLE.
- Non-visible line: E0 enters DONE, E0+1 enters IDLE; `addr_valid` never asserted.
- Outputs in IDLE: BG_ADDR, `addr_valid`=0, `counter_finished`=0.
- Abort at edge Ea: outputs take idle values at Ea.
- Async reset assertion forces reset values immediately, regardless of clock, including mid-RUN. Deassertion takes effect on the next falling edge.
- Minimum start-to-start period: SPRITE_W+2 cycles.

## Structure
- Shared package `sprite_pkg`:
  - state enumeration
  - descriptor field-offset helper constants, derived from COORD_W/OFFSET_W
  - default BG_ADDR function
- One natural sub-module, `sprite_addr_calc`: combinational offset/row/col → address with mirroring, instantiated once.
- FSM, counters and output registers live in the top level.

## Test plan
- Defaults; x=100, y=50, offset=3, no mirror, pixel_y=52, one-cycle start → addresses 1240…1259 on consecutive edges with `addr_valid`=1, then one cycle of `counter_finished`=1 with address 16383.
- Same setup, mirror_x=1 → 1259 down to 1240.
- Same setup, mirror_y=1 → 1540…1559.
- pixel_y=70 or pixel_y=49 → `addr_valid` never asserted; `counter_finished` pulses at E0; address stays 16383.
- Start, then drop `sprite_on` after 5 addresses (1240…1244) → next edge shows 16383 with `addr_valid`=0, and no finished pulse.
- Assert `reset_n` mid-RUN → outputs become 16383/0/0 immediately; after release, `sprite_on` held high restarts a full line from col 0.
